// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module : dmem_port_arbiter
// Brief  : Shares the MemArray data port between the CPU load/store stage
//          (port A, fixed priority) and the loader / debug DMA (port B),
//          with a starvation guard and a bounded locked-burst mode for B.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
   parameter int DBITS      = 16,
   parameter int ABITS      = 12,
   parameter int STARVE_MAX = 8,
   parameter int BURST_MAX  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_req,
   input  logic             a_we,
   input  logic [DBITS-1:0] a_addr,
   input  logic [DBITS-1:0] a_wdata,
   output logic             a_gnt,
   output logic [DBITS-1:0] a_rdata,
   output logic             a_rvalid,
   input  logic             b_req,
   input  logic             b_we,
   input  logic [DBITS-1:0] b_addr,
   input  logic [DBITS-1:0] b_wdata,
   input  logic             b_lock,
   output logic             b_gnt,
   output logic [DBITS-1:0] b_rdata,
   output logic             b_rvalid,
   output logic [ABITS-1:0] mem_addr,
   output logic [DBITS-1:0] mem_din,
   output logic             mem_we,
   input  logic [DBITS-1:0] mem_dout
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [SW-1:0] starve_lim = SW'(STARVE_MAX);
   localparam logic [BW-1:0] burst_lim  = BW'(BURST_MAX);

   // Owner of the previous cycle
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_OWN_A  = 2'd1,
      S_OWN_B  = 2'd2,
      S_LOCK_B = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [SW-1:0]   starve_cnt, starve_nxt;
   logic [BW-1:0]   burst_cnt, burst_nxt;
   logic [BW-1:0]   beats_after;
   logic            grant_a, grant_b;

   // Byte-lane bit and high address bits are decoded outside this block
   logic unused_addr;
   assign unused_addr = ^{a_addr[0], b_addr[0],
                          a_addr[DBITS-1:ABITS+1], b_addr[DBITS-1:ABITS+1]};

   // Grant decision, ownership/burst/starvation next values
   always_comb begin
      grant_a     = 1'b0;
      grant_b     = 1'b0;
      state_nxt   = S_IDLE;
      burst_nxt   = '0;
      starve_nxt  = '0;
      beats_after = BW'(1);

      if (state == S_LOCK_B && b_req && burst_cnt < burst_lim)
         grant_b = 1'b1;
      else if (b_req && starve_cnt == starve_lim)
         grant_b = 1'b1;
      else if (a_req)
         grant_a = 1'b1;
      else if (b_req)
         grant_b = 1'b1;

      // A beat continuing a lock extends the count; any other B beat starts at 1
      if (state == S_LOCK_B && grant_b)
         beats_after = burst_cnt + BW'(1);

      if (grant_a) begin
         state_nxt = S_OWN_A;
      end else if (grant_b) begin
         if (b_lock && beats_after < burst_lim) begin
            state_nxt = S_LOCK_B;
            burst_nxt = beats_after;
         end else begin
            state_nxt = S_OWN_B;
         end
      end

      if (b_req && !grant_b)
         starve_nxt = (starve_cnt == starve_lim) ? starve_cnt : starve_cnt + SW'(1);
   end

   assign a_gnt    = grant_a;
   assign b_gnt    = grant_b;
   assign mem_addr = grant_b ? b_addr[ABITS:1] : a_addr[ABITS:1];
   assign mem_din  = grant_b ? b_wdata : a_wdata;
   assign mem_we   = (grant_a & a_we) | (grant_b & b_we);

   // Ownership state and counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         starve_cnt <= '0;
         burst_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         burst_cnt  <= burst_nxt;
      end
   end

   // Read return: capture memory data for a granted read, pulse rvalid once
   always_ff @(posedge clk) begin
      if (reset) begin
         a_rdata  <= '0;
         a_rvalid <= 1'b0;
         b_rdata  <= '0;
         b_rvalid <= 1'b0;
      end else begin
         a_rvalid <= grant_a & ~a_we;
         b_rvalid <= grant_b & ~b_we;
         if (grant_a && !a_we)
            a_rdata <= mem_dout;
         if (grant_b && !b_we)
            b_rdata <= mem_dout;
      end
   end

endmodule

`default_nettype wire
